mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the core's single memory bus between the instruction-fetch requester (I) and the data-access requester (D).
- Grants one requester at a time and holds the grant for a whole burst.
- Routes bus responses back to the owner only; the non-owner sees no response, which its cache turns into i_wait/d_wait for the pipeline hazard logic.
- D has priority, since a stalled memory stage freezes the whole pipe. A bounded starvation counter guarantees I forward progress.

Parameters:
- ADDR_W, 64, request address width.
- DATA_W, 64, data width per beat.
- LEN_W, 4, burst-length field width (beats-1).
- STARVE_MAX, 4, consecutive D grants allowed while I is pending before I is forced; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- i_valid  in  1  I request valid; held until its last beat completes.
- i_is_write  in  1  I write flag; tied 0 in practice but routed.
- i_addr  in  ADDR_W  I address.
- i_len  in  LEN_W  I beats-1.
- i_wdata  in  DATA_W  I write data.
- i_strobe  in  DATA_W/8  I byte strobes.
- i_ready  out  1  I beat accepted/returned.
- i_last  out  1  I final beat.
- i_rdata  out  DATA_W  I read data.
- d_valid, d_is_write, d_addr, d_len, d_wdata, d_strobe  in  as I  D request fields.
- d_ready, d_last, d_rdata  out  as I  D response fields.
- m_valid, m_is_write, m_addr, m_len, m_wdata, m_strobe  out  as I  bus request.
- m_ready  in  1  bus beat handshake.
- m_last  in  1  bus final beat.
- m_rdata  in  DATA_W  bus read data.
- owner_i, owner_d  out  1  current grant, one-hot or both 0.

Behaviour:
- FSM states: IDLE, OWN_I, OWN_D. The state is registered; owner_i=(state==OWN_I) and owner_d=(state==OWN_D).
- Reset (async, resetn=0):
  - state=IDLE, starve_cnt=0.
  - All outputs 0 immediately; m_valid drops in the same cycle reset asserts.
- Arbitration runs only in IDLE, with the next state decided from the current cycle's valids:
  - d_valid && !(i_valid && starve_cnt==STARVE_MAX) -> OWN_D.
  - else i_valid -> OWN_I.
  - else stay in IDLE.
- Grant latency: a request first seen at cycle N in IDLE appears on m_* at cycle N+1. m_valid is never 1 in IDLE.
- In OWN_x:
  - m_* mux the fields of x combinationally; m_valid = x_valid.
  - x_ready=m_ready, x_last=m_last, x_rdata=m_rdata.
  - The other requester gets ready=0 and last=0; its rdata may mirror m_rdata but is don't-care.
- Release: on m_ready && m_last in OWN_x, next state is IDLE.
  - This gives exactly one bubble cycle between bursts.
  - A requester re-asserting valid in the same cycle is evaluated in that IDLE cycle.
- Starvation counter (3..4 bits, saturating at STARVE_MAX):
  - On IDLE->OWN_D with i_valid=1: starve_cnt+1.
  - On IDLE->OWN_I: starve_cnt=0.
  - On IDLE->OWN_D with i_valid=0: starve_cnt=0.
- Owner rule: the owner must hold valid and all fields stable until ready&&last.
  - If the owner drops valid mid-burst, the grant is still held until m_last.
  - A simulation-only assertion flags this case.
- Single-beat bursts (len=0) require m_last with the first m_ready.
  - m_last without m_ready is ignored.
  - Beats with m_ready in IDLE are ignored and must not reach any requester.
- Simultaneous i_valid and d_valid with starve_cnt<STARVE_MAX: D wins and I keeps waiting.

Decomposition:
- Shared package pipes: typedef mbus_req_t {valid, is_write, addr, len, wdata, strobe} and mbus_resp_t {ready, last, rdata}; typedef arb_state_t enum {IDLE, OWN_I, OWN_D}.
- Package common: constant STARVE_MAX default.
- No sub-module is needed. The request mux is a function or always_comb in-module.

Test Plan:
- Reset mid-burst: OWN_D with 2 of 4 beats done, resetn=0 -> m_valid=0 the same cycle, owner_d=0. After release, the first arbitration starts from IDLE with starve_cnt=0.
- Lone I read: i_valid=1 at cycle 0 with len=3 and m_ready every cycle starting cycle 1 -> m_valid=1 at cycle 1. i_ready is high cycles 1-4, i_last only at cycle 4 with m_rdata echoed. State is IDLE at cycle 5 and d_ready stays 0 throughout.
- Contention: i_valid and d_valid both rise at cycle 0 -> owner_d at cycle 1. After D's m_last, there is one IDLE cycle, then owner_i.
- Starvation: with STARVE_MAX=4, I held valid and D re-requests every IDLE -> D is granted 4 times. The 5th arbitration grants I even though d_valid=1, and starve_cnt returns to 0.
- Single-beat write: d_valid=1, d_is_write=1, len=0, strobe=8'h0F, with m_ready and m_last together -> m_strobe=8'h0F for exactly one cycle, then IDLE.
- Stray response: m_ready=1 and m_last=1 pulsed in IDLE -> i_ready, d_ready, i_last and d_last all stay 0, and the state is unchanged.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared bus request/response types, FSM states and default widths for mem_bus_arbiter
package mem_bus_arbiter_pkg;
   localparam int MBUS_ADDR_W    = 64;
   localparam int MBUS_DATA_W    = 64;
   localparam int MBUS_LEN_W     = 4;
   localparam int STARVE_MAX_DEF = 4;
   typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} arb_state_t;
   typedef struct packed {
      logic                     valid;
      logic                     is_write;
      logic [MBUS_ADDR_W-1:0]   addr;
      logic [MBUS_LEN_W-1:0]    len;
      logic [MBUS_DATA_W-1:0]   wdata;
      logic [MBUS_DATA_W/8-1:0] strobe;
   } mbus_req_t;
   typedef struct packed {
      logic                   ready;
      logic                   last;
      logic [MBUS_DATA_W-1:0] rdata;
   } mbus_resp_t;
endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants the shared memory bus to I or D one burst at a time, D first with a starvation bound for I
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W     = MBUS_ADDR_W,
   parameter int DATA_W     = MBUS_DATA_W,
   parameter int LEN_W      = MBUS_LEN_W,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                i_valid,
   input  logic                i_is_write,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic [LEN_W-1:0]    i_len,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [DATA_W/8-1:0] i_strobe,
   output logic                i_ready,
   output logic                i_last,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_valid,
   input  logic                d_is_write,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [LEN_W-1:0]    d_len,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_strobe,
   output logic                d_ready,
   output logic                d_last,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_valid,
   output logic                m_is_write,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [LEN_W-1:0]    m_len,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_strobe,
   input  logic                m_ready,
   input  logic                m_last,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                owner_i,
   output logic                owner_d
);
   localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);
   arb_state_t r_state, w_state_next;
   logic [3:0] r_starve_cnt, w_starve_next;
   logic       w_pick_d;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= IDLE;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_next;
         r_starve_cnt <= w_starve_next;
      end
   end
   // D wins unless I has already sat through STARVE_MAX back-to-back D grants
   assign w_pick_d = d_valid && !(i_valid && r_starve_cnt == C_STARVE_MAX);
   always_comb begin
      w_state_next  = r_state;
      w_starve_next = r_starve_cnt;
      if (r_state == IDLE) begin
         if (w_pick_d) begin
            w_state_next  = OWN_D;
            w_starve_next = i_valid ? r_starve_cnt + 4'd1 : 4'd0;
         end else if (i_valid) begin
            w_state_next  = OWN_I;
            w_starve_next = '0;
         end
      end else if (m_ready && m_last) begin
         w_state_next = IDLE;
      end
   end
   assign owner_i    = r_state == OWN_I;
   assign owner_d    = r_state == OWN_D;
   assign m_valid    = owner_d ? d_valid    : owner_i ? i_valid    : 1'b0;
   assign m_is_write = owner_d ? d_is_write : owner_i ? i_is_write : 1'b0;
   assign m_addr     = owner_d ? d_addr     : owner_i ? i_addr     : '0;
   assign m_len      = owner_d ? d_len      : owner_i ? i_len      : '0;
   assign m_wdata    = owner_d ? d_wdata    : owner_i ? i_wdata    : '0;
   assign m_strobe   = owner_d ? d_strobe   : owner_i ? i_strobe   : '0;
   // responses reach the owner only; stray beats in IDLE fall on the floor
   assign i_ready    = owner_i && m_ready;
   assign i_last     = owner_i && m_last;
   assign i_rdata    = owner_i ? m_rdata : '0;
   assign d_ready    = owner_d && m_ready;
   assign d_last     = owner_d && m_last;
   assign d_rdata    = owner_d ? m_rdata : '0;
   a_owner_holds_valid: assert property (@(posedge clk) disable iff (!resetn)
      !((owner_i && !i_valid) || (owner_d && !d_valid)));
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios with a queued-expectation monitor for mem_bus_arbiter
module tb_mem_bus_arbiter;
   logic        clk = 1'b0;
   logic        resetn;
   logic        i_valid, i_is_write, i_ready, i_last;
   logic [63:0] i_addr, i_wdata, i_rdata;
   logic [3:0]  i_len;
   logic [7:0]  i_strobe;
   logic        d_valid, d_is_write, d_ready, d_last;
   logic [63:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_len;
   logic [7:0]  d_strobe;
   logic        m_valid, m_is_write, m_ready, m_last;
   logic [63:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_len;
   logic [7:0]  m_strobe;
   logic        owner_i, owner_d;
   int checks = 0;
   int failures = 0;
   typedef struct packed {
      logic        oi, od, mv, mw;
      logic [63:0] ma;
      logic [3:0]  ml;
      logic [63:0] mwd;
      logic [7:0]  ms;
      logic        ir, il, dr, dl;
      logic [63:0] rd;
   } obs_t;
   typedef struct packed {
      logic [15:0] tag;
      obs_t        o;
   } item_t;
   item_t q[$];
   always #5 clk = ~clk;
   mem_bus_arbiter dut (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_is_write(i_is_write), .i_addr(i_addr), .i_len(i_len),
      .i_wdata(i_wdata), .i_strobe(i_strobe), .i_ready(i_ready), .i_last(i_last), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_is_write(d_is_write), .d_addr(d_addr), .d_len(d_len),
      .d_wdata(d_wdata), .d_strobe(d_strobe), .d_ready(d_ready), .d_last(d_last), .d_rdata(d_rdata),
      .m_valid(m_valid), .m_is_write(m_is_write), .m_addr(m_addr), .m_len(m_len),
      .m_wdata(m_wdata), .m_strobe(m_strobe), .m_ready(m_ready), .m_last(m_last), .m_rdata(m_rdata),
      .owner_i(owner_i), .owner_d(owner_d)
   );
   function automatic obs_t observe();
      obs_t o;
      o.oi  = owner_i;
      o.od  = owner_d;
      o.mv  = m_valid;
      o.mw  = m_is_write;
      o.ma  = m_addr;
      o.ml  = m_len;
      o.mwd = m_wdata;
      o.ms  = m_strobe;
      o.ir  = i_ready;
      o.il  = i_last;
      o.dr  = d_ready;
      o.dl  = d_last;
      o.rd  = owner_i ? i_rdata : owner_d ? d_rdata : 64'h0;
      return o;
   endfunction
   always @(negedge clk) begin : mon
      obs_t  a;
      item_t e;
      a = observe();
      if (a.mv || a.ir || a.il || a.dr || a.dl) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output act=%h exp=none", a);
         end else begin
            e = q.pop_front();
            if (a !== e.o) begin
               failures++;
               $display("FAIL beat_%0d act=%h exp=%h", e.tag, a, e.o);
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic clr();
      {i_valid, i_is_write, i_addr, i_len, i_wdata, i_strobe} = '0;
      {d_valid, d_is_write, d_addr, d_len, d_wdata, d_strobe} = '0;
      {m_ready, m_last, m_rdata} = '0;
   endtask
   task automatic set_i(input logic [63:0] a, input logic [3:0] l);
      i_valid = 1'b1; i_is_write = 1'b0; i_addr = a; i_len = l;
      i_wdata = 64'h1111_2222_0000_0000 ^ a; i_strobe = 8'hFF;
   endtask
   task automatic set_d(input logic w, input logic [63:0] a, input logic [3:0] l, input logic [7:0] s, input logic [63:0] wd);
      d_valid = 1'b1; d_is_write = w; d_addr = a; d_len = l; d_wdata = wd; d_strobe = s;
   endtask
   task automatic bus(input logic r, input logic l, input logic [63:0] rd);
      m_ready = r; m_last = l; m_rdata = rd;
   endtask
   task automatic exp_own(input logic is_d, input logic rdy, input logic lst, input logic [15:0] tag);
      item_t it;
      it.tag  = tag;
      it.o.oi = !is_d;
      it.o.od = is_d;
      it.o.mv = 1'b1;
      it.o.mw  = is_d ? d_is_write : i_is_write;
      it.o.ma  = is_d ? d_addr     : i_addr;
      it.o.ml  = is_d ? d_len      : i_len;
      it.o.mwd = is_d ? d_wdata    : i_wdata;
      it.o.ms  = is_d ? d_strobe   : i_strobe;
      it.o.ir = !is_d && rdy;
      it.o.il = !is_d && lst;
      it.o.dr = is_d && rdy;
      it.o.dl = is_d && lst;
      it.o.rd = m_rdata;
      q.push_back(it);
   endtask
   task automatic chk_bit(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%b exp=%b", nm, act, exp);
      end
   endtask
   task automatic chk_idle(input string nm);
      logic [14:0] v;
      v = {owner_i, owner_d, m_valid, m_strobe, i_ready, i_last, d_ready, d_last};
      checks++;
      if (v !== 15'h0) begin
         failures++;
         $display("FAIL %s act=%h exp=0", nm, v);
      end
   endtask
   task automatic chk_zero(input string nm);
      logic [275:0] v;
      v = {i_ready, i_last, i_rdata, d_ready, d_last, d_rdata, m_valid, m_is_write,
           m_addr, m_len, m_wdata, m_strobe, owner_i, owner_d};
      checks++;
      if (v !== '0) begin
         failures++;
         $display("FAIL %s act=%h exp=0", nm, v);
      end
   endtask
   initial begin
      clr();
      resetn = 1'b0;
      tick();
      tick();
      #1 chk_zero("reset_outputs");
      resetn = 1'b1;
      // lone I read, 4 beats
      tick(); set_i(64'h1000, 4'd3); #1 chk_idle("i_req_idle");
      for (int b = 0; b < 4; b++) begin
         tick(); bus(1'b1, b == 3, 64'(160 + b)); exp_own(1'b0, 1'b1, b == 3, 16'(b));
      end
      tick(); clr(); #1 chk_idle("i_done_idle");
      // contention: D first, one bubble, then I
      tick(); set_i(64'h2000, 4'd0); set_d(1'b0, 64'h3000, 4'd1, 8'hFF, 64'h0); #1 chk_idle("both_req_idle");
      tick(); bus(1'b1, 1'b0, 64'hB0); exp_own(1'b1, 1'b1, 1'b0, 16'd16); #1 chk_bit("contention_owner_d", owner_d, 1'b1);
      tick(); bus(1'b1, 1'b1, 64'hB1); exp_own(1'b1, 1'b1, 1'b1, 16'd17);
      tick(); d_valid = 1'b0; bus(1'b0, 1'b0, 64'h0); #1 chk_idle("contention_bubble");
      tick(); bus(1'b1, 1'b1, 64'hB2); exp_own(1'b0, 1'b1, 1'b1, 16'd18); #1 chk_bit("contention_then_i", owner_i, 1'b1);
      tick(); clr(); #1 chk_idle("contention_done");
      // starvation: four D grants, then I is forced, then counter restarts
      for (int g = 0; g < 4; g++) begin
         tick(); set_i(64'h4000, 4'd0); set_d(1'b0, 64'h5000 + 64'(g), 4'd0, 8'hFF, 64'h0); bus(1'b0, 1'b0, 64'h0);
         #1 chk_idle("starve_arb_idle");
         tick(); bus(1'b1, 1'b1, 64'(192 + g)); exp_own(1'b1, 1'b1, 1'b1, 16'(20 + g));
      end
      tick(); bus(1'b0, 1'b0, 64'h0); #1 chk_idle("starve_idle");
      tick(); bus(1'b1, 1'b1, 64'hCC); exp_own(1'b0, 1'b1, 1'b1, 16'd24); #1 chk_bit("starve_forces_i", owner_i, 1'b1);
      tick(); bus(1'b0, 1'b0, 64'h0); #1 chk_idle("starve_after_i_idle");
      tick(); bus(1'b1, 1'b1, 64'hCD); exp_own(1'b1, 1'b1, 1'b1, 16'd25); #1 chk_bit("starve_cnt_cleared", owner_d, 1'b1);
      tick(); clr(); #1 chk_idle("starve_done");
      // single-beat D write
      tick(); set_d(1'b1, 64'h6000, 4'd0, 8'h0F, 64'hDEAD_BEEF_0000_0001); #1 chk_idle("wr_req_idle");
      tick(); bus(1'b1, 1'b1, 64'h0); exp_own(1'b1, 1'b1, 1'b1, 16'd30); #1 chk_bit("wr_m_is_write", m_is_write, 1'b1);
      tick(); clr(); #1 chk_idle("wr_one_cycle");
      // stray response in IDLE
      for (int k = 0; k < 2; k++) begin
         tick(); clr(); bus(1'b1, 1'b1, 64'hEE); #1 chk_idle("stray_resp");
      end
      tick(); clr(); set_i(64'h7000, 4'd0); #1 chk_idle("stray_then_req");
      tick(); bus(1'b1, 1'b1, 64'hE1); exp_own(1'b0, 1'b1, 1'b1, 16'd31); #1 chk_bit("stray_state_kept", owner_i, 1'b1);
      tick(); clr(); #1 chk_idle("stray_done");
      // reset mid-burst with the starvation counter at its limit
      for (int g = 0; g < 3; g++) begin
         tick(); set_i(64'h8000, 4'd0); set_d(1'b0, 64'h9000 + 64'(g), 4'd0, 8'hFF, 64'h0); bus(1'b0, 1'b0, 64'h0);
         #1 chk_idle("pre_rst_arb_idle");
         tick(); bus(1'b1, 1'b1, 64'(224 + g)); exp_own(1'b1, 1'b1, 1'b1, 16'(32 + g));
      end
      tick(); set_d(1'b0, 64'h9100, 4'd3, 8'hFF, 64'h0); bus(1'b0, 1'b0, 64'h0); #1 chk_idle("rst_burst_req_idle");
      tick(); bus(1'b1, 1'b0, 64'hF0); exp_own(1'b1, 1'b1, 1'b0, 16'd40);
      tick(); bus(1'b1, 1'b0, 64'hF1); exp_own(1'b1, 1'b1, 1'b0, 16'd41);
      tick(); bus(1'b1, 1'b0, 64'hF2);
      #1 chk_bit("rst_pre_m_valid", m_valid, 1'b1);
      resetn = 1'b0;
      #1 chk_bit("rst_m_valid_drop", m_valid, 1'b0);
      chk_bit("rst_owner_d", owner_d, 1'b0);
      chk_zero("rst_mid_outputs");
      tick(); clr();
      tick(); resetn = 1'b1; set_i(64'hA000, 4'd0); set_d(1'b0, 64'hB000, 4'd0, 8'hFF, 64'h0); #1 chk_idle("post_rst_idle");
      tick(); bus(1'b1, 1'b1, 64'hF3); exp_own(1'b1, 1'b1, 1'b1, 16'd42); #1 chk_bit("post_rst_d_wins", owner_d, 1'b1);
      tick(); clr();
      tick();
      tick();
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL pending_expectations act=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
